axi4_mem_slv: RTL and testbench
===============================

// Module: axi4_mem_slv
// PURPOSE
//  Parametrised AXI4 full-slave memory model for chip-level benches; backs the Rift2Chip memory_0 port.
//  Generalises the fixed 128-bit SRAM slave: configurable data/addr/ID width and depth, FIXED/INCR/WRAP bursts,
//  narrow transfers, SLVERR reporting, programmable read latency, optional pseudo-random ready throttling.
//  Read and write channels are independent FSMs sharing one array `ram`, which benches preload by hierarchical reference.
// PARAMETERS
//  DW      128  data width, bits; power of 2, 32..512
//  AW      32   AXI address width
//  MEM_AW  14   log2(array depth in DW-bit words)
//  IDW     4    AXI ID width
//  RD_LAT  0    extra cycles between AR accept and first R beat (0..15)
//  BP_EN   0    1 = LFSR throttling of aw_ready/w_ready/ar_ready
// PORTS
//  clock     in   1        clock
//  reset     in   1        synchronous, active-high reset
//  aw_valid/aw_ready  in/out 1; aw_id in IDW; aw_addr in AW; aw_len in 8; aw_size in 3; aw_burst in 2
//  w_valid/w_ready    in/out 1; w_data in DW; w_strb in DW/8; w_last in 1
//  b_valid/b_ready    out/in 1; b_id out IDW; b_resp out 2
//  ar_valid/ar_ready  in/out 1; ar_id in IDW; ar_addr in AW; ar_len in 8; ar_size in 3; ar_burst in 2
//  r_valid/r_ready    out/in 1; r_id out IDW; r_data out DW; r_resp out 2; r_last out 1
// BEHAVIOUR
//  Reset: all valids 0, aw/ar_ready 1 (0 if BP_EN and LFSR bit0=0), w_ready 0, ids/resp/data/last 0,
//   FSMs idle, LFSR=16'hACE1. Array `ram` never cleared; reset mid-burst drops the burst, written beats persist.
//  Index = addr[MEM_AW+log2(DW/8)-1 : log2(DW/8)]; upper address bits ignored (aliasing).
//  Beat address: FIXED constant; INCR += 2**size; WRAP wraps in (len+1)*2**size aligned window.
//  Burst code 3, WRAP with len not in {1,3,7,15}, or 2**size > DW/8 -> SLVERR, burst runs to completion, no ram access.
//  Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE:
//   W_IDLE: aw_ready=1 (gated); on aw handshake latch id/addr/len/size/burst, beat cnt=0 -> W_DATA.
//   W_DATA: w_ready=1 (gated); each handshake writes bytes with w_strb set, same cycle; cnt++.
//    Beats after cnt>len are not written. On w_last handshake -> W_RESP; resp SLVERR if w_last not at cnt==len.
//   W_RESP: b_valid=1, b_id=latched id; hold until b_ready -> W_IDLE. aw_ready=0 outside W_IDLE.
//  Read FSM R_IDLE->R_WAIT->R_DATA->R_IDLE:
//   R_IDLE: ar_ready=1 (gated); on handshake latch fields -> R_WAIT (RD_LAT>0) else R_DATA.
//   R_WAIT: count RD_LAT cycles -> R_DATA. First r_valid at accept cycle +1+RD_LAT.
//   R_DATA: r_valid=1, r_data = full word at beat index (narrow: whole lane word returned), r_id latched,
//    r_last=1 when cnt==len. Outputs stable while r_valid&&!r_ready. Handshake advances one beat/cycle;
//    handshake with r_last -> R_IDLE (ar_ready may reassert next cycle, no same-cycle re-accept).
//  Same-cycle read and write of one word: read returns pre-write data (ram read registered on beat launch).
//  BP_EN: LFSR (x^16+x^14+x^13+x^11+1) steps every cycle; bit0=0 forces aw/w/ar_ready low.
//   Never deasserts any valid this block drives once raised.
//  ID width: b_id/r_id echo full IDW bits, no reordering; one outstanding burst per direction.
// TESTING
//  T1 AW INCR addr 0x8000_0010 len 3 size 4, 4 W beats strb all-ones -> B OKAY id echoed; ram[1..4] updated.
//  T2 AR WRAP addr 0x30 len 3 size 4 -> R beats from words 3,0,1,2; r_last on 4th; RD_LAT=3 gives first r_valid at accept+4.
//  T3 WRAP len 2 or burst 2'b11 -> B/R resp 2'b10 on all beats; ram unchanged.
//  T4 w_last on beat 1 of len 3 burst -> B SLVERR; only beats 0,1 written.
//  T5 r_ready held low 5 cycles mid-burst -> r_data/r_last stable; same-cycle RW on one word returns old data.
//  T6 BP_EN=1, 1000 random bursts vs scoreboard; reset asserted mid-burst -> all valids 0 next cycle, FSMs idle.

Source files
------------

// File: rtl/axi4_mem_slv.sv
// AXI4 full-slave memory model: independent read and write burst FSMs sharing one word array `ram`.
// Supports FIXED/INCR/WRAP bursts, narrow beats, SLVERR, programmable read latency, LFSR ready throttling.
module axi4_mem_slv #(
  parameter int DW     = 128,
  parameter int AW     = 32,
  parameter int MEM_AW = 14,
  parameter int IDW    = 4,
  parameter int RD_LAT = 0,
  parameter bit BP_EN  = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [IDW-1:0]    aw_id,
  input  logic [AW-1:0]     aw_addr,
  input  logic [7:0]        aw_len,
  input  logic [2:0]        aw_size,
  input  logic [1:0]        aw_burst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DW-1:0]     w_data,
  input  logic [DW/8-1:0]   w_strb,
  input  logic              w_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [IDW-1:0]    b_id,
  output logic [1:0]        b_resp,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [IDW-1:0]    ar_id,
  input  logic [AW-1:0]     ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [IDW-1:0]    r_id,
  output logic [DW-1:0]     r_data,
  output logic [1:0]        r_resp,
  output logic              r_last
);

  localparam int SW    = DW / 8;
  localparam int OFFW  = $clog2(SW);
  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [3:0] LAT_LAST = 4'(RD_LAT > 0 ? RD_LAT - 1 : 0);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  function automatic logic cfg_err(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok) || (int'(size) > OFFW);
  endfunction

  // WRAP keeps the upper address bits of the (len+1)*2**size window and wraps the low ones.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] step, mask;
    step = AW'(1) << size;
    mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:     next_addr = addr + step;
    endcase
  endfunction

  logic [DW-1:0] ram [DEPTH];

  w_state_e      r_wr_state;
  logic [IDW-1:0] r_wr_id;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_len;
  logic [2:0]    r_wr_size;
  logic [1:0]    r_wr_burst;
  logic          r_wr_err;
  logic [8:0]    r_wr_cnt;

  r_state_e      r_rd_state;
  logic [AW-1:0] r_rd_addr;
  logic [7:0]    r_rd_len;
  logic [2:0]    r_rd_size;
  logic [1:0]    r_rd_burst;
  logic          r_rd_err;
  logic [7:0]    r_rd_cnt;
  logic [3:0]    r_rd_lat;
  logic [15:0]   r_lfsr;

  logic          w_gate, w_aw_hs, w_w_hs, w_ar_hs, w_wr_en, w_ar_err;
  logic [AW-1:0] w_wr_next, w_rd_next;

  assign w_gate    = !BP_EN || r_lfsr[0];
  assign aw_ready  = (r_wr_state == W_IDLE) && w_gate;
  assign w_ready   = (r_wr_state == W_DATA) && w_gate;
  assign ar_ready  = (r_rd_state == R_IDLE) && w_gate;
  assign w_aw_hs   = aw_valid && aw_ready;
  assign w_w_hs    = w_valid && w_ready;
  assign w_ar_hs   = ar_valid && ar_ready;
  assign w_ar_err  = cfg_err(ar_len, ar_size, ar_burst);
  assign w_wr_next = next_addr(r_wr_addr, r_wr_len, r_wr_size, r_wr_burst);
  assign w_rd_next = next_addr(r_rd_addr, r_rd_len, r_rd_size, r_rd_burst);
  assign w_wr_en   = w_w_hs && !r_wr_err && (r_wr_cnt <= {1'b0, r_wr_len});

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  // NOTE: the array has no reset; benches preload it and contents must survive a reset.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      for (int b = 0; b < SW; b++) begin
        if (w_strb[b]) ram[r_wr_addr[OFFW +: MEM_AW]][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_state <= W_IDLE;
      r_wr_id    <= '0;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_size  <= '0;
      r_wr_burst <= '0;
      r_wr_err   <= 1'b0;
      r_wr_cnt   <= '0;
      b_valid    <= 1'b0;
      b_id       <= '0;
      b_resp     <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        W_IDLE: if (w_aw_hs) begin
          r_wr_id    <= aw_id;
          r_wr_addr  <= aw_addr;
          r_wr_len   <= aw_len;
          r_wr_size  <= aw_size;
          r_wr_burst <= aw_burst;
          r_wr_err   <= cfg_err(aw_len, aw_size, aw_burst);
          r_wr_cnt   <= '0;
          r_wr_state <= W_DATA;
        end
        W_DATA: if (w_w_hs) begin
          r_wr_addr <= w_wr_next;
          r_wr_cnt  <= r_wr_cnt[8] ? r_wr_cnt : r_wr_cnt + 9'd1;
          if (w_last) begin
            b_valid    <= 1'b1;
            b_id       <= r_wr_id;
            b_resp     <= (r_wr_err || (r_wr_cnt != {1'b0, r_wr_len})) ? RESP_SLVERR : RESP_OKAY;
            r_wr_state <= W_RESP;
          end
        end
        W_RESP: if (b_ready) begin
          b_valid    <= 1'b0;
          r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Each beat's word is read on the edge that launches it, so a same-edge write is not seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_size  <= '0;
      r_rd_burst <= '0;
      r_rd_err   <= 1'b0;
      r_rd_cnt   <= '0;
      r_rd_lat   <= '0;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_data     <= '0;
      r_resp     <= RESP_OKAY;
      r_last     <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: if (w_ar_hs) begin
          r_rd_addr  <= ar_addr;
          r_rd_len   <= ar_len;
          r_rd_size  <= ar_size;
          r_rd_burst <= ar_burst;
          r_rd_err   <= w_ar_err;
          r_rd_cnt   <= '0;
          r_rd_lat   <= '0;
          r_id       <= ar_id;
          if (RD_LAT == 0) begin
            r_valid    <= 1'b1;
            r_data     <= w_ar_err ? '0 : ram[ar_addr[OFFW +: MEM_AW]];
            r_resp     <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
            r_last     <= (ar_len == 8'd0);
            r_rd_state <= R_DATA;
          end else begin
            r_rd_state <= R_WAIT;
          end
        end
        R_WAIT: if (r_rd_lat == LAT_LAST) begin
          r_valid    <= 1'b1;
          r_data     <= r_rd_err ? '0 : ram[r_rd_addr[OFFW +: MEM_AW]];
          r_resp     <= r_rd_err ? RESP_SLVERR : RESP_OKAY;
          r_last     <= (r_rd_len == 8'd0);
          r_rd_state <= R_DATA;
        end else begin
          r_rd_lat <= r_rd_lat + 4'd1;
        end
        R_DATA: if (r_valid && r_ready) begin
          if (r_last) begin
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_rd_state <= R_IDLE;
          end else begin
            r_rd_addr <= w_rd_next;
            r_rd_cnt  <= r_rd_cnt + 8'd1;
            r_data    <= r_rd_err ? '0 : ram[w_rd_next[OFFW +: MEM_AW]];
            r_last    <= (8'(r_rd_cnt + 8'd1) == r_rd_len);
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mem_slv.sv
// Bench for axi4_mem_slv: directed burst scenarios plus a throttled random phase, checked
// against a bench-side word model and B/R expectation queues.
module tb_axi4_mem_slv;
  localparam int DW = 128, AW = 32, MEM_AW = 6, IDW = 4, RD_LAT = 3, TMO = 400;

  logic clock = 1'b0, reset = 1'b1;
  logic aw_valid = 0, aw_ready; logic [IDW-1:0] aw_id = '0; logic [AW-1:0] aw_addr = '0;
  logic [7:0] aw_len = '0; logic [2:0] aw_size = '0; logic [1:0] aw_burst = '0;
  logic w_valid = 0, w_ready, w_last = 0; logic [DW-1:0] w_data = '0; logic [DW/8-1:0] w_strb = '0;
  logic b_valid, b_ready = 0; logic [IDW-1:0] b_id; logic [1:0] b_resp;
  logic ar_valid = 0, ar_ready; logic [IDW-1:0] ar_id = '0; logic [AW-1:0] ar_addr = '0;
  logic [7:0] ar_len = '0; logic [2:0] ar_size = '0; logic [1:0] ar_burst = '0;
  logic r_valid, r_ready = 0, r_last; logic [IDW-1:0] r_id; logic [DW-1:0] r_data; logic [1:0] r_resp;

  axi4_mem_slv #(.DW(DW), .AW(AW), .MEM_AW(MEM_AW), .IDW(IDW), .RD_LAT(RD_LAT), .BP_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last)
  );

  always #5 clock = ~clock;

  typedef struct { logic [IDW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; logic chk; } r_exp_t;
  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;

  r_exp_t q_r[$];
  b_exp_t q_b[$];
  logic [DW-1:0] mdl [1 << MEM_AW];
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, first_cyc = 0;

  always @(posedge clock) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic bad_cfg(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    return burst == 2'b11 || size > 3'd4 ||
           (burst == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int k);
    logic [31:0] cur, sz, tot, lo;
    cur = a; sz = 32'd1 << size; tot = (32'(len) + 1) * sz; lo = a - (a % tot);
    for (int i = 0; i < k; i++) begin
      if (burst != 2'b00) cur = cur + sz;
      if (burst == 2'b10 && cur >= lo + tot) cur = cur - tot;
    end
    return cur;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 4) % (1 << MEM_AW));
  endfunction

  task automatic aw_send(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    while (!aw_ready && n < TMO) begin @(negedge clock); n++; end
    if (n == TMO) check("aw_ready_timeout", aw_ready, 1'b1);
    @(negedge clock);
    aw_valid = 0;
  endtask

  task automatic ar_send(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    while (!ar_ready && n < TMO) begin @(negedge clock); n++; end
    if (n == TMO) check("ar_ready_timeout", ar_ready, 1'b1);
    acc_cyc = cyc;
    @(negedge clock);
    ar_valid = 0;
  endtask

  task automatic w_beat(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
    int n = 0;
    w_valid = 1; w_data = data; w_strb = strb; w_last = last;
    while (!w_ready && n < TMO) begin @(negedge clock); n++; end
    if (n == TMO) check("w_ready_timeout", w_ready, 1'b1);
    @(negedge clock);
    w_valid = 0; w_last = 0;
  endtask

  task automatic b_recv(input bit thr);
    int n = 0;
    b_exp_t e;
    forever begin
      b_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      if ((b_valid && b_ready) || n == TMO) break;
      @(negedge clock); n++;
    end
    if (n == TMO) check("b_valid_timeout", b_valid, 1'b1);
    else begin
      e = q_b.pop_front();
      check("b_id", b_id, e.id);
      check("b_resp", b_resp, e.resp);
      @(negedge clock);
    end
    b_ready = 0;
  endtask

  task automatic r_recv(input int nb, input bit thr);
    r_exp_t e;
    for (int k = 0; k < nb; k++) begin
      int n = 0;
      forever begin
        r_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        if ((r_valid && r_ready) || n == TMO) break;
        @(negedge clock); n++;
      end
      if (n == TMO) begin
        check("r_valid_timeout", r_valid, 1'b1);
        break;
      end
      if (k == 0) first_cyc = cyc;
      e = q_r.pop_front();
      check("r_id", r_id, e.id);
      check("r_resp", r_resp, e.resp);
      check("r_last", r_last, e.last);
      if (e.chk) check("r_data", r_data, e.data);
      @(negedge clock);
    end
    r_ready = 0;
  endtask

  task automatic push_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    logic err = bad_cfg(len, size, burst);
    for (int k = 0; k <= int'(len); k++)
      q_r.push_back('{id, err ? '0 : mdl[widx(beat_addr(addr, len, size, burst, k))],
                      err ? 2'b10 : 2'b00, k == int'(len), !err});
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit thr);
    push_read(id, addr, len, size, burst);
    ar_send(id, addr, len, size, burst);
    r_recv(int'(len) + 1, thr);
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input int last_at, input bit rnd_strb, input bit thr);
    logic err = bad_cfg(len, size, burst);
    logic [DW-1:0] d;
    logic [DW/8-1:0] s;
    int wi;
    q_b.push_back('{id, (err || last_at != int'(len)) ? 2'b10 : 2'b00});
    aw_send(id, addr, len, size, burst);
    for (int k = 0; k < nbeats; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      s = rnd_strb ? 16'($urandom) : '1;
      if (!err && k <= int'(len)) begin
        wi = widx(beat_addr(addr, len, size, burst, k));
        for (int b = 0; b < DW / 8; b++) if (s[b]) mdl[wi][8*b +: 8] = d[8*b +: 8];
      end
      w_beat(d, s, k == last_at);
    end
    b_recv(thr);
  endtask

  initial begin
    logic [DW-1:0] wd;
    r_exp_t e;
    int n;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_aw_ready", aw_ready, 1'b1);
    check("rst_ar_ready", ar_ready, 1'b1);
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_outs", {b_id, b_resp, r_id, r_resp, r_last}, '0);
    check("rst_r_data", r_data, '0);
    reset = 0;
    @(negedge clock);

    // Fill the whole array through the write channel so the model starts defined.
    do_write(4'h0, 32'h0, 8'd63, 3'd4, 2'b01, 64, 63, 0, 0);

    // T1: aliased INCR write to words 1..4, then read back.
    do_write(4'hA, 32'h8000_0010, 8'd3, 3'd4, 2'b01, 4, 3, 0, 0);
    do_read(4'h5, 32'h0000_0010, 8'd3, 3'd4, 2'b01, 0);

    // T2: WRAP read from word 3 returns words 3,0,1,2 with RD_LAT cycles of extra latency.
    do_read(4'h3, 32'h30, 8'd3, 3'd4, 2'b10, 0);
    check("t2_first_r_latency", 32'(first_cyc - acc_cyc), 32'(1 + RD_LAT));

    // T3: illegal bursts answer SLVERR and leave the array alone.
    do_write(4'h1, 32'h100, 8'd2, 3'd4, 2'b10, 3, 2, 0, 0);
    do_write(4'h2, 32'h200, 8'd1, 3'd4, 2'b11, 2, 1, 0, 0);
    do_write(4'h3, 32'h300, 8'd0, 3'd5, 2'b01, 1, 0, 0, 0);
    do_read(4'h4, 32'h100, 8'd2, 3'd4, 2'b10, 0);
    do_read(4'h5, 32'h200, 8'd3, 3'd4, 2'b11, 0);
    do_read(4'h6, 32'h100, 8'd3, 3'd4, 2'b01, 0);
    do_read(4'h7, 32'h200, 8'd1, 3'd4, 2'b01, 0);
    do_read(4'h8, 32'h300, 8'd0, 3'd4, 2'b01, 0);

    // T4: early w_last; only the first two beats land.
    do_write(4'h7, 32'h400, 8'd3, 3'd4, 2'b01, 2, 1, 0, 0);
    do_read(4'h8, 32'h400, 8'd3, 3'd4, 2'b01, 0);

    // Narrow INCR beats with random strobes; reads return whole words.
    do_write(4'h9, 32'h504, 8'd3, 3'd2, 2'b01, 4, 3, 1, 0);
    do_read(4'hA, 32'h504, 8'd3, 3'd2, 2'b01, 0);
    do_read(4'hB, 32'h500, 8'd3, 3'd3, 2'b00, 0);

    // T5a: stall r_ready for 5 cycles after the first beat.
    push_read(4'h1, 32'h600, 8'd3, 3'd4, 2'b01);
    ar_send(4'h1, 32'h600, 8'd3, 3'd4, 2'b01);
    r_recv(1, 0);
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_valid", r_valid, 1'b1);
      check("t5_stall_data", r_data, q_r[0].data);
      check("t5_stall_last", r_last, q_r[0].last);
      @(negedge clock);
    end
    r_recv(3, 0);

    // T5b: launch read beat 1 (word 41) on the same edge that writes word 41.
    aw_send(4'h2, 32'h290, 8'd0, 3'd4, 2'b01);
    push_read(4'h3, 32'h280, 8'd1, 3'd4, 2'b01);
    ar_send(4'h3, 32'h280, 8'd1, 3'd4, 2'b01);
    n = 0;
    while (!(r_valid && w_ready) && n < TMO) begin @(negedge clock); n++; end
    if (n == TMO) check("t5_rw_timeout", r_valid && w_ready, 1'b1);
    else begin
      e = q_r.pop_front();
      check("t5_rw_beat0", r_data, e.data);
      wd = {$urandom, $urandom, $urandom, $urandom};
      w_valid = 1; w_data = wd; w_strb = '1; w_last = 1; r_ready = 1;
      @(negedge clock);
      w_valid = 0; w_last = 0; r_ready = 0;
      q_b.push_back('{4'h2, 2'b00});
      r_recv(1, 0);
      mdl[41] = wd;
      b_recv(0);
      do_read(4'h4, 32'h290, 8'd0, 3'd4, 2'b01, 0);
    end

    // Reset with a write burst in W_DATA and a read burst stalled in R_DATA.
    aw_send(4'h5, 32'h700, 8'd3, 3'd4, 2'b01);
    wd = {$urandom, $urandom, $urandom, $urandom};
    mdl[widx(32'h700)] = wd;
    w_beat(wd, '1, 1'b0);
    ar_send(4'h6, 32'h7C0, 8'd3, 3'd4, 2'b01);
    n = 0;
    while (!r_valid && n < TMO) begin @(negedge clock); n++; end
    check("mid_r_valid", r_valid, 1'b1);
    check("mid_aw_ready_busy", aw_ready, 1'b0);
    check("mid_ar_ready_busy", ar_ready, 1'b0);
    reset = 1;
    @(negedge clock);
    check("rst2_r_valid", r_valid, 1'b0);
    check("rst2_b_valid", b_valid, 1'b0);
    check("rst2_w_ready", w_ready, 1'b0);
    check("rst2_aw_ready", aw_ready, 1'b1);
    check("rst2_ar_ready", ar_ready, 1'b1);
    check("rst2_r_last", r_last, 1'b0);
    reset = 0;
    q_r.delete();
    q_b.delete();
    @(negedge clock);
    do_read(4'h7, 32'h700, 8'd3, 3'd4, 2'b01, 0);

    // T6: random bursts with throttled readies on both sides.
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] bu; logic [7:0] ln; logic [2:0] sz; logic [31:0] ad; logic [IDW-1:0] id;
      bu = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) bu = 2'b11;
      if (bu == 2'b10) begin
        ln = 8'((2 << $urandom_range(0, 3)) - 1);
        if ($urandom_range(0, 19) == 0) ln = 8'd2;
      end else ln = 8'($urandom_range(0, 7));
      sz = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) sz = 3'd5;
      ad = $urandom & ~((32'd1 << sz) - 1);
      id = 4'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(id, ad, ln, sz, bu, int'(ln) + 1, int'(ln), 1, 1);
      else                           do_read(id, ad, ln, sz, bu, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
